pixel_byte_assembler: RTL and testbench
=======================================

PIXEL_BYTE_ASSEMBLER -- requirements
Module: pixel_byte_assembler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023: idle cycles allowed between bytes of one pixel before the partial pixel is discarded.
REQ-002 SHALL use MAX_PIXEL_BITS (24) and BYTES_PER_PIXEL (3) from the shared parameters header.
REQ-003 SHALL have port clk_i  input  1  the single clock.
REQ-004 SHALL have port nreset_i  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port byte_i  input  8  external pixel byte.
REQ-006 SHALL have port byte_valid_i  input  1  byte strobe.
REQ-007 SHALL have port frame_start_i  input  1  frame sync; clears the partial pixel and the error flag.
REQ-008 SHALL have port out_pixel_o  output  MAX_PIXEL_BITS  assembled RGB pixel {R,G,B}, which feeds the gray/sobel pipeline in_pixel_i.
REQ-009 SHALL have port px_rdy_o  output  1  one-cycle pulse; out_pixel_o is valid while it is high.
REQ-010 SHALL have port busy_o  output  1  high while a partial pixel (1 or 2 bytes) is held.
REQ-011 SHALL have port err_o  output  1  sticky timeout flag.

Function
REQ-012 SHALL implement FSM states WAIT_R, WAIT_G, WAIT_B; a byte event advances WAIT_R->WAIT_G->WAIT_B->WAIT_R.
REQ-013 SHALL place the WAIT_R byte in [23:16], the WAIT_G byte in [15:8] and the WAIT_B byte in [7:0].
REQ-014 SHALL treat a byte event, with the sync feature out, as any clock edge where byte_valid_i=1, each such cycle counting as one byte.
REQ-015 SHALL register out_pixel_o and px_rdy_o on the cycle after the WAIT_B byte event, with px_rdy_o high for exactly one cycle.
REQ-016 SHALL update out_pixel_o only when px_rdy_o is asserted and hold it stable otherwise.
REQ-017 SHALL drive busy_o high exactly in states WAIT_G and WAIT_B.
REQ-018 SHALL run the timeout counter only in WAIT_G/WAIT_B, reset it on every byte event, and, when it reaches TIMEOUT_CYCLES, return to WAIT_R, drop the partial bytes, set err_o and assert no px_rdy_o.
REQ-019 SHALL, on frame_start_i=1, force WAIT_R, clear the timeout counter and err_o, and take a byte event on the same cycle as the R byte of the new pixel.
REQ-020 SHALL give the frame_start_i clear priority over a timeout that expires in the same cycle, leaving err_o=0.
REQ-021 SHALL size the timeout counter as $clog2(TIMEOUT_CYCLES+1) bits with no wrap-around, saturating at expiry.

Reset
REQ-022 SHALL, while nreset_i=0, asynchronously drive state=WAIT_R, out_pixel_o=0, px_rdy_o=0, busy_o=0, err_o=0, timeout counter=0 and synchronizer flops=0.
REQ-023 SHALL discard any partial pixel on reset mid-pixel and emit no px_rdy_o after release until three new byte events have occurred.

Configuration
REQ-024 SHALL, when SYNC_STROBE_EN is defined, pass byte_valid_i through a two-flop synchronizer plus rising-edge detector.
REQ-025 SHALL, with SYNC_STROBE_EN defined, count one byte event per 0->1 transition only, adding 2 cycles of latency, with byte_i sampled at the edge-detect cycle; byte_i must be held stable at least 3 cycles after the strobe rises.
REQ-026 SHALL, without SYNC_STROBE_EN, use byte_valid_i directly as a synchronous level-qualified strobe per REQ-014.

Structure
REQ-027 SHALL take BYTES_PER_PIXEL and the state typedef asm_state_t {WAIT_R, WAIT_G, WAIT_B} from the shared parameters header.
REQ-028 SHALL place synchronizer and edge detection in a sub-module strobe_sync, instantiated only under SYNC_STROBE_EN.

Verification
REQ-029 SHALL cover: sync out, bytes 0x12,0x34,0x56 on consecutive cycles -> one cycle later out_pixel_o=0x123456 and px_rdy_o high for exactly 1 cycle.
REQ-030 SHALL cover: 0xAA,0xBB, then 1023 idle cycles -> err_o=1, busy_o=0, no px_rdy_o; then 0x01,0x02,0x03 -> out_pixel_o=0x010203 with err_o still 1.
REQ-031 SHALL cover: 0x11,0x22, then frame_start_i together with byte 0x77, then 0x88,0x99 -> out_pixel_o=0x778899 and err_o=0.
REQ-032 SHALL cover: nreset_i pulsed low after 2 bytes -> all outputs 0 immediately; then 0xC0,0xFF,0xEE -> 0xC0FFEE.
REQ-033 SHALL cover: SYNC_STROBE_EN defined, byte_valid_i held high 5 cycles per byte for 0xDE,0xAD,0xBE -> exactly one pixel 0xDEADBE with px_rdy_o 3 cycles after the third rising edge.
REQ-034 SHALL cover: 6 back-to-back bytes 0x01..0x06 -> px_rdy_o pulses 0x010203 then 0x040506, 3 cycles apart.

Source files
------------

// File: rtl/pixel_byte_assembler_pkg.sv
// Shared parameters for the pixel byte assembler: pixel geometry, the
// assembler state type and a small packing helper.
package pixel_byte_assembler_pkg;

    localparam int MAX_PIXEL_BITS  = 24;
    localparam int BYTES_PER_PIXEL = 3;
    localparam int BYTE_BITS       = MAX_PIXEL_BITS / BYTES_PER_PIXEL;

    typedef enum logic [1:0] {
        WAIT_R = 2'd0,
        WAIT_G = 2'd1,
        WAIT_B = 2'd2
    } asm_state_t;

    // Packs three colour bytes into an {R,G,B} pixel word.
    function automatic logic [MAX_PIXEL_BITS-1:0] pack_pixel(
        input logic [BYTE_BITS-1:0] r,
        input logic [BYTE_BITS-1:0] g,
        input logic [BYTE_BITS-1:0] b
    );
        return {r, g, b};
    endfunction

endpackage

// File: rtl/pixel_byte_assembler_strobe_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous
// byte strobe. rise_o is high for one cycle per 0->1 transition of strobe_i,
// two clock cycles after the transition is first captured.
module strobe_sync (
    input  logic clk_i,
    input  logic nreset_i,
    input  logic strobe_i,
    output logic rise_o
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronize the strobe and keep one delayed copy for edge detection.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= strobe_i;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign rise_o = sync_r & ~prev_r;

endmodule

// File: rtl/pixel_byte_assembler.sv
// Assembles three consecutive bytes into a 24-bit {R,G,B} pixel with a
// per-pixel inter-byte timeout and frame-sync resynchronization.
// Optional feature macro: SYNC_STROBE_EN -- byte_valid_i is treated as an
// asynchronous strobe, synchronized and edge-detected (one byte per rise).
module pixel_byte_assembler
    import pixel_byte_assembler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                      clk_i,
    input  logic                      nreset_i,
    input  logic [BYTE_BITS-1:0]      byte_i,
    input  logic                      byte_valid_i,
    input  logic                      frame_start_i,
    output logic [MAX_PIXEL_BITS-1:0] out_pixel_o,
    output logic                      px_rdy_o,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Expiry fires on the idle edge that would bring the count to TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);

    asm_state_t                state_r;
    logic [BYTE_BITS-1:0]      r_byte_r;
    logic [BYTE_BITS-1:0]      g_byte_r;
    logic [CNT_W-1:0]          cnt_r;
    logic [MAX_PIXEL_BITS-1:0] out_pixel_r;
    logic                      px_rdy_r;
    logic                      busy_r;
    logic                      err_r;
    logic                      byte_event_s;

`ifdef SYNC_STROBE_EN
    logic rise_s;

    strobe_sync u_strobe_sync (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .strobe_i (byte_valid_i),
        .rise_o   (rise_s)
    );

    assign byte_event_s = rise_s;
`else
    assign byte_event_s = byte_valid_i;
`endif

    // Assembler FSM: byte capture, pixel output, timeout and frame-sync handling.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_r     <= WAIT_R;
            r_byte_r    <= {BYTE_BITS{1'b0}};
            g_byte_r    <= {BYTE_BITS{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            out_pixel_r <= {MAX_PIXEL_BITS{1'b0}};
            px_rdy_r    <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            px_rdy_r <= 1'b0;
            if (frame_start_i) begin
                // Frame sync wins over everything, including a same-cycle timeout.
                err_r <= 1'b0;
                cnt_r <= {CNT_W{1'b0}};
                if (byte_event_s) begin
                    r_byte_r <= byte_i;
                    state_r  <= WAIT_G;
                    busy_r   <= 1'b1;
                end else begin
                    state_r  <= WAIT_R;
                    busy_r   <= 1'b0;
                end
            end else if (byte_event_s) begin
                cnt_r <= {CNT_W{1'b0}};
                case (state_r)
                    WAIT_R: begin
                        r_byte_r <= byte_i;
                        state_r  <= WAIT_G;
                        busy_r   <= 1'b1;
                    end
                    WAIT_G: begin
                        g_byte_r <= byte_i;
                        state_r  <= WAIT_B;
                        busy_r   <= 1'b1;
                    end
                    WAIT_B: begin
                        out_pixel_r <= pack_pixel(r_byte_r, g_byte_r, byte_i);
                        px_rdy_r    <= 1'b1;
                        state_r     <= WAIT_R;
                        busy_r      <= 1'b0;
                    end
                    default: begin
                        state_r <= WAIT_R;
                        busy_r  <= 1'b0;
                    end
                endcase
            end else if (state_r != WAIT_R) begin
                if (cnt_r >= CNT_LAST) begin
                    // Partial pixel abandoned; counter parks at its saturated value.
                    state_r <= WAIT_R;
                    busy_r  <= 1'b0;
                    err_r   <= 1'b1;
                    cnt_r   <= CNT_SAT;
                end else begin
                    cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign out_pixel_o = out_pixel_r;
    assign px_rdy_o    = px_rdy_r;
    assign busy_o      = busy_r;
    assign err_o       = err_r;

endmodule

// File: tb/tb_pixel_byte_assembler.sv
// Scoreboard bench for pixel_byte_assembler: stimulus pushes expected pixels,
// a negedge monitor pops and compares whenever px_rdy_o is high.
module tb_pixel_byte_assembler;

    logic        clk;
    logic        nreset_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        frame_start_i;
    logic [23:0] out_pixel_o;
    logic        px_rdy_o;
    logic        busy_o;
    logic        err_o;

    typedef struct {
        logic [23:0] pix;
        logic        err;
        int          gap;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_m;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_rdy = 0;
    logic prev_rdy = 1'b0;
    logic [23:0] last_pix = 24'h0;

    pixel_byte_assembler #(.TIMEOUT_CYCLES(1023)) dut (
        .clk_i         (clk),
        .nreset_i      (nreset_i),
        .byte_i        (byte_i),
        .byte_valid_i  (byte_valid_i),
        .frame_start_i (frame_start_i),
        .out_pixel_o   (out_pixel_o),
        .px_rdy_o      (px_rdy_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [23:0] pix, input logic err, input int gap);
        exp_t x;
        x.pix = pix;
        x.err = err;
        x.gap = gap;
        sb_q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
`ifdef SYNC_STROBE_EN
        byte_i = b;
        byte_valid_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`else
        byte_i = b;
        byte_valid_i = 1'b1;
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
`endif
    endtask

    // Monitor: pop and compare on every px_rdy_o, and police pulse width and hold.
    always @(negedge clk) begin
        cyc++;
        if (!nreset_i) begin
            last_pix = out_pixel_o;
        end else if (px_rdy_o) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_px: got %h expected no pixel", out_pixel_o);
            end else begin
                e_m = sb_q.pop_front();
                check("pixel", {8'h00, out_pixel_o}, {8'h00, e_m.pix});
                check("err_at_px", {31'd0, err_o}, {31'd0, e_m.err});
                if (e_m.gap != 0) check("px_gap", cyc - last_rdy, e_m.gap);
            end
            check("px_pulse_width", {31'd0, prev_rdy}, 32'd0);
            last_rdy = cyc;
            last_pix = out_pixel_o;
        end else if (out_pixel_o !== last_pix) begin
            check("pix_hold", {8'h00, out_pixel_o}, {8'h00, last_pix});
            last_pix = out_pixel_o;
        end
        prev_rdy = px_rdy_o;
    end

    initial begin
        nreset_i = 1'b0;
        byte_i = 8'h00;
        byte_valid_i = 1'b0;
        frame_start_i = 1'b0;
        idle(2);
        check("rst_pixel", {8'h00, out_pixel_o}, 32'd0);
        check("rst_rdy", {31'd0, px_rdy_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        nreset_i = 1'b1;
        idle(2);

`ifndef SYNC_STROBE_EN
        // Basic pixel assembly
        push(24'h123456, 1'b0, 0);
        send_byte(8'h12);
        check("busy_after_r", {31'd0, busy_o}, 32'd1);
        send_byte(8'h34);
        send_byte(8'h56);
        check("busy_after_b", {31'd0, busy_o}, 32'd0);
        idle(3);

        // Timeout boundary, then recovery with sticky error
        send_byte(8'hAA);
        send_byte(8'hBB);
        idle(1022);
        check("to_err_before", {31'd0, err_o}, 32'd0);
        check("to_busy_before", {31'd0, busy_o}, 32'd1);
        idle(1);
        check("to_err_after", {31'd0, err_o}, 32'd1);
        check("to_busy_after", {31'd0, busy_o}, 32'd0);
        idle(3);
        push(24'h010203, 1'b1, 0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        idle(2);
        check("err_sticky", {31'd0, err_o}, 32'd1);

        // Frame start with same-cycle R byte
        send_byte(8'h11);
        send_byte(8'h22);
        push(24'h778899, 1'b0, 0);
        frame_start_i = 1'b1;
        send_byte(8'h77);
        frame_start_i = 1'b0;
        check("fs_err_clear", {31'd0, err_o}, 32'd0);
        check("fs_busy", {31'd0, busy_o}, 32'd1);
        send_byte(8'h88);
        send_byte(8'h99);
        idle(2);

        // Frame start colliding with timeout expiry
        send_byte(8'h01);
        send_byte(8'h02);
        idle(1022);
        frame_start_i = 1'b1;
        idle(1);
        frame_start_i = 1'b0;
        check("fs_prio_err", {31'd0, err_o}, 32'd0);
        check("fs_prio_busy", {31'd0, busy_o}, 32'd0);
        idle(2);
`endif

        // Reset mid-pixel
        send_byte(8'hC1);
        send_byte(8'hC2);
        nreset_i = 1'b0;
        #1;
        check("mid_rst_pixel", {8'h00, out_pixel_o}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        check("mid_rst_err", {31'd0, err_o}, 32'd0);
        check("mid_rst_rdy", {31'd0, px_rdy_o}, 32'd0);
        @(posedge clk);
        #1;
        nreset_i = 1'b1;
        idle(1);
        push(24'hC0FFEE, 1'b0, 0);
        send_byte(8'hC0);
        send_byte(8'hFF);
        send_byte(8'hEE);
        idle(2);

`ifdef SYNC_STROBE_EN
        // Held strobes: one byte per rising edge
        push(24'hDEADBE, 1'b0, 0);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        idle(4);
`else
        // Back-to-back pixels
        push(24'h010203, 1'b0, 0);
        push(24'h040506, 1'b0, 3);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        idle(3);
`endif

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        check("sb_drain", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
